// File: rtl/muldiv_seq.sv
// Sequential 32-cycle unsigned multiplier/divider (MUL, MULHU, DIVU, REMU).
// Stalls the core while busy and pulses ready with the result in OUT.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       cnt;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   sum, rem_sh;
  logic             take;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ready     = 1'b0;
    unique case (state)
      IDLE: begin
        stall = valid;
        if (valid) state_nxt = mode[1] ? DIV : MUL;
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (cnt == 5'd31) state_nxt = OUT;
      end
      OUT: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add (MUL) or restoring shift-subtract (DIV) step.
  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    sum    = '0;
    rem_sh = '0;
    take   = 1'b0;
    if (state == MUL) begin
      sum    = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      rem_sh = {hi, lo[WIDTH-1]};
      take   = rem_sh >= {1'b0, b_q};
      // The true difference is below 2^WIDTH, so the low word is exact.
      hi_nxt = take ? rem_sh[WIDTH-1:0] - b_q
                    : rem_sh[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], take};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      op  <= '0;
      a_q <= '0;
      b_q <= '0;
      hi  <= '0;
      lo  <= '0;
      out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            cnt <= '0;
            op  <= mode;
            a_q <= in_A;
            b_q <= in_B;
            hi  <= '0;
            lo  <= mode[1] ? in_A : in_B;
          end
        end
        MUL, DIV: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            out <= op[0] ? hi_nxt : lo_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
